// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the decimal counter family.
//   NIBBLE_W : bits per BCD digit
//   BCD_MAX  : largest legal digit value (9)
//   BCD_ZERO : digit value zero
//   bcd_sat  : clamps a 4-bit nibble into the legal BCD range 0..9
package bcd_pkg;

  localparam int         NIBBLE_W = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic [3:0] bcd_sat(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down counter.
//   clk     : rising-edge clock
//   clr     : asynchronous active-high reset, digit -> 0
//   load    : synchronous load strobe, takes priority over dec
//   ld_val  : nibble to load; values above 9 are stored as 9
//   dec     : decrement this digit on the next edge (0 wraps to 9)
//   d       : current digit value
//   is_zero : 1 when the digit is 0, feeds the borrow chain
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       dec,
  output logic [3:0] d,
  output logic       is_zero
);

  logic [3:0] d_q;
  logic [3:0] d_d;

  always_comb begin
    d_d = d_q;
    if (load) begin
      d_d = bcd_sat(ld_val);
    end else if (dec) begin
      d_d = (d_q == BCD_ZERO) ? BCD_MAX : (d_q - 4'd1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      d_q <= BCD_ZERO;
    end else begin
      d_q <= d_d;
    end
  end

  assign d       = d_q;
  assign is_zero = (d_q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit synchronous BCD down counter with parallel load.
//   clk        : rising-edge clock
//   clr        : asynchronous active-high reset (q=0, pulses cleared)
//   load       : synchronous load strobe, wins over en
//   load_val   : BCD load value, nibble i -> digit i (nibbles >9 saturate to 9)
//   en         : count enable, one decrement per enabled edge
//   q          : current count, nibble i is digit i (digit 0 least significant)
//   zero       : combinational, 1 when every digit is 0
//   borrow_out : registered one-cycle pulse when the count wraps 0 -> all nines
//   load_err   : registered one-cycle flag after a load containing a nibble >9
// Parameters: DIGITS (1..8), WRAP (1 = wrap to all nines, 0 = stop at zero).
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         load,
  input  logic [NIBBLE_W*DIGITS-1:0]   load_val,
  input  logic                         en,
  output logic [NIBBLE_W*DIGITS-1:0]   q,
  output logic                         zero,
  output logic                         borrow_out,
  output logic                         load_err
);

  logic [DIGITS-1:0] dig_zero;
  logic [DIGITS-1:0] dec;
  // lower_zero[i] = digits 0..i-1 are all zero; lower_zero[DIGITS] = whole count zero.
  logic [DIGITS:0]   lower_zero;
  logic              all_zero;
  logic              count_ok;
  logic              bad_nibble;

  logic borrow_out_q, borrow_out_d;
  logic load_err_q,   load_err_d;

  assign lower_zero[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign lower_zero[g+1] = lower_zero[g] & dig_zero[g];
    assign dec[g]          = count_ok & lower_zero[g];

    bcd_down_digit u_digit (
      .clk     (clk),
      .clr     (clr),
      .load    (load),
      .ld_val  (load_val[g*NIBBLE_W +: NIBBLE_W]),
      .dec     (dec[g]),
      .d       (q[g*NIBBLE_W +: NIBBLE_W]),
      .is_zero (dig_zero[g])
    );
  end

  assign all_zero = lower_zero[DIGITS];

  // Without WRAP the counter parks at zero: suppress every decrement there.
  assign count_ok = en & ~load & (WRAP | ~all_zero);

  always_comb begin
    bad_nibble = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[i*NIBBLE_W +: NIBBLE_W] > BCD_MAX) begin
        bad_nibble = 1'b1;
      end
    end
  end

  always_comb begin
    borrow_out_d = en & ~load & all_zero & WRAP;
    load_err_d   = load & bad_nibble;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      borrow_out_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      borrow_out_q <= borrow_out_d;
      load_err_q   <= load_err_d;
    end
  end

  assign zero       = all_zero;
  assign borrow_out = borrow_out_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter: three instances
//   u_a : DIGITS=2, WRAP=1
//   u_b : DIGITS=2, WRAP=0
//   u_c : DIGITS=3, WRAP=1 (full-period run)
module tb_bcd_down_counter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic clr;

  logic       a_load, a_en, a_zero, a_borrow, a_lerr;
  logic [7:0] a_val, a_q;
  logic       b_load, b_en, b_zero, b_borrow, b_lerr;
  logic [7:0] b_val, b_q;
  logic        c_load, c_en, c_zero, c_borrow, c_lerr;
  logic [11:0] c_val, c_q;

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) u_a (
    .clk(clk), .clr(clr), .load(a_load), .load_val(a_val), .en(a_en),
    .q(a_q), .zero(a_zero), .borrow_out(a_borrow), .load_err(a_lerr));

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b0)) u_b (
    .clk(clk), .clr(clr), .load(b_load), .load_val(b_val), .en(b_en),
    .q(b_q), .zero(b_zero), .borrow_out(b_borrow), .load_err(b_lerr));

  bcd_down_counter #(.DIGITS(3), .WRAP(1'b1)) u_c (
    .clk(clk), .clr(clr), .load(c_load), .load_val(c_val), .en(c_en),
    .q(c_q), .zero(c_zero), .borrow_out(c_borrow), .load_err(c_lerr));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd3(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // ---------------- drivers ----------------
  // Inputs change just after the falling edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic a_do_load(input logic [7:0] v);
    a_load = 1'b1;
    a_val  = v;
    tick();
    a_load = 1'b0;
  endtask

  task automatic b_do_load(input logic [7:0] v);
    b_load = 1'b1;
    b_val  = v;
    tick();
    b_load = 1'b0;
  endtask

  int c_borrows;
  int c_first;
  int c_second;
  int prev;
  int m;
  logic nib_ok;

  initial begin
    clr = 1'b1;
    a_load = 1'b0; a_en = 1'b0; a_val = '0;
    b_load = 1'b0; b_en = 1'b0; b_val = '0;
    c_load = 1'b0; c_en = 1'b0; c_val = '0;
    @(negedge clk);

    // reset state
    check("rst_q",      a_q, 8'h00);
    check("rst_zero",   a_zero, 1'b1);
    check("rst_borrow", a_borrow, 1'b0);
    check("rst_lerr",   a_lerr, 1'b0);
    clr = 1'b0;
    tick();
    check("rst_hold_q", a_q, 8'h00);

    // load 21 and count three times, borrow into digit 1 at 20->19
    a_do_load(8'h21);
    check("ld21_q",    a_q, 8'h21);
    check("ld21_lerr", a_lerr, 1'b0);
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h19);
    exp_q.push_back(32'h18);
    a_en = 1'b1;
    repeat (3) begin
      tick();
      check("cnt21", a_q, exp_q.pop_front());
    end
    a_en = 1'b0;
    tick();
    check("hold_q", a_q, 8'h18);

    // wrap through zero
    a_do_load(8'h01);
    a_en = 1'b1;
    tick();
    check("wrap_q00",    a_q, 8'h00);
    check("wrap_zero",   a_zero, 1'b1);
    check("wrap_b0",     a_borrow, 1'b0);
    tick();
    check("wrap_q99",    a_q, 8'h99);
    check("wrap_b1",     a_borrow, 1'b1);
    check("wrap_nz",     a_zero, 1'b0);
    tick();
    check("wrap_q98",    a_q, 8'h98);
    check("wrap_b2",     a_borrow, 1'b0);

    // load with en, saturating a bad nibble
    a_load = 1'b1;
    a_val  = 8'hB4;
    tick();
    a_load = 1'b0;
    a_en   = 1'b0;
    check("sat_q",      a_q, 8'h94);
    check("sat_lerr",   a_lerr, 1'b1);
    check("sat_borrow", a_borrow, 1'b0);
    tick();
    check("sat_q2",     a_q, 8'h94);
    check("sat_lerr2",  a_lerr, 1'b0);
    a_do_load(8'h9F);
    check("sat_lo_q",    a_q, 8'h99);
    check("sat_lo_lerr", a_lerr, 1'b1);

    // asynchronous clear mid-count, then resume
    a_do_load(8'h37);
    check("pre_clr_q", a_q, 8'h37);
    a_en = 1'b1;
    #2 clr = 1'b1;
    #1;
    check("aclr_q",      a_q, 8'h00);
    check("aclr_zero",   a_zero, 1'b1);
    check("aclr_borrow", a_borrow, 1'b0);
    @(negedge clk);
    check("aclr_held", a_q, 8'h00);
    clr = 1'b0;
    tick();
    check("resume_q",      a_q, 8'h99);
    check("resume_borrow", a_borrow, 1'b1);
    a_en = 1'b0;
    tick();
    check("resume_hold",  a_q, 8'h99);
    check("resume_b0",    a_borrow, 1'b0);

    // one-shot instance stops at zero
    b_do_load(8'h02);
    exp_q.push_back(32'h01);
    repeat (4) exp_q.push_back(32'h00);
    b_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("oneshot_q", b_q, exp_q.pop_front());
      check("oneshot_b", b_borrow, 1'b0);
      if (i >= 1) check("oneshot_zero", b_zero, 1'b1);
    end
    b_en = 1'b0;

    // full period of the 3-digit instance, model-checked every cycle
    check("c_start", c_q, 12'h000);
    c_borrows = 0;
    c_first   = -1;
    c_second  = -1;
    m = 0;
    c_en = 1'b1;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      prev = m;
      m = (m == 0) ? 999 : m - 1;
      tick();
      check("full_q", c_q, to_bcd3(m));
      check("full_b", c_borrow, (prev == 0));
      nib_ok = (c_q[3:0] <= 4'd9) && (c_q[7:4] <= 4'd9) && (c_q[11:8] <= 4'd9);
      check("full_nib", nib_ok, 1'b1);
      if (c_borrow) begin
        c_borrows++;
        if (c_first < 0) c_first = cyc;
        else if (c_second < 0) c_second = cyc;
      end
    end
    c_en = 1'b0;
    check("full_count",   c_borrows, 2);
    check("full_spacing", c_second - c_first, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Synchronous multi-digit BCD down counter: the counting-down counterpart of the team's mod-10 up counter.
- Counts 9→0 per digit, with cascaded borrows across DIGITS digits.
- Supports parallel load, a count enable, zero detect and a wrap/borrow pulse.
- Sits in countdown timers and display paths; its q output uses the same 4-bit-per-digit BCD encoding as the up counter.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); digit 0 is least significant.
- WRAP, 1, 1 = from all-zero wrap to all-nines and pulse borrow_out; 0 = hold at all-zero (one-shot timer).

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge.
- clr  input  1  asynchronous, active-high reset.
- load  input  1  synchronous parallel load strobe.
- load_val  input  4*DIGITS  BCD load value; nibble i goes to digit i.
- en  input  1  count enable; one decrement per enabled clock.
- q  output  4*DIGITS  current BCD count; nibble i is digit i.
- zero  output  1  combinational; 1 when every digit is 0.
- borrow_out  output  1  registered one-cycle pulse on wrap.
- load_err  output  1  registered; 1 for one cycle after a load in which any nibble was >9.

Behaviour:
- Reset (clr=1, asynchronous, independent of clk): q=0, borrow_out=0, load_err=0. zero therefore reads 1.
- Release of clr is synchronous to the next rising clk edge. Asserting clr mid-count aborts the count immediately.
- Priority at each edge: clr > load > en > hold.

Load (load=1):
- q takes load_val on the next edge, whatever en is.
- Any nibble >9 is stored as 9 (saturate), and load_err=1 on the following cycle.
- borrow_out=0 on a load cycle.

Count (load=0, en=1):
- Digit i decrements when digits 0..i-1 are all 0, i.e. the ripple-borrow chain is computed combinationally from the current q. Digit 0 always decrements.
- A decrementing digit at 0 becomes 9. Otherwise it becomes d-1.
- The whole counter changes in one edge, so latency is 1 clk from en to the new q. There are no ripple-clock stages.
- All digits at 0 with WRAP=1: next q = all nines and borrow_out=1 for exactly that one cycle.
- All digits at 0 with WRAP=0: q holds at 0 and borrow_out stays 0 (saturating stop).

Hold (load=0, en=0):
- q is unchanged.
- borrow_out=0 and load_err=0 (both are single-cycle pulses).

Invariant:
- q never holds a nibble >9 after reset, because every load path saturates and every count path produces only 0..9.

Cascading:
- borrow_out of one instance may drive en of the next instance as a one-cycle-late carry. Back-to-back wraps with en held high must pulse borrow_out every 10^DIGITS cycles.

Decomposition:
- Shared package bcd_pkg: localparam BCD_MAX=4'd9, BCD_ZERO=4'd0, NIBBLE_W=4, and a function bcd_sat(nibble) returning min(nibble,9).
- Sub-module bcd_down_digit:
  - Ports clk, clr, load, ld_val[3:0], dec, d[3:0], is_zero.
  - One registered nibble with saturate-on-load and 0→9 wrap.
- The top level instantiates DIGITS copies with a generate loop. It also contains the borrow chain (dec[i] = en & all lower is_zero), the WRAP hold logic and the borrow_out/load_err registers.

Test Plan:
- Reset: assert clr asynchronously between clock edges with en=1 and q=37 → q=00, zero=1, borrow_out=0 immediately, before the next edge. Release clr → counting resumes on the next edge (99 if WRAP=1).
- Load and count, DIGITS=2, WRAP=1: load 0x21, then en=1 for 3 cycles → q sequence 21, 20, 19, 18. The digit-1 borrow occurs at 20→19.
- Wrap: DIGITS=2, WRAP=1, load 0x01, en=1 → 00 with zero=1, then 99 with borrow_out=1 for exactly one cycle, then 98 with borrow_out=0.
- One-shot: WRAP=0, load 0x02, en=1 for 5 cycles → 01, 00, 00, 00, 00. borrow_out never asserts and zero stays 1 once q reaches 00.
- Priority and saturation: load=1 and en=1 together with load_val=0xB4 → q=94, not 93. load_err=1 for one cycle, then 0.
- Full period: DIGITS=3, WRAP=1, en held high for 2000 cycles from 000 → borrow_out pulses exactly twice, spaced 1000 cycles apart. Every q nibble stays ≤9, checked on each cycle.
